// File: rtl/rtp_packet_scheduler.sv
// rtp_packet_scheduler
// Splits each video frame into line-aligned RTP packets and hands one
// descriptor per packet to the transmit state machine over valid/ready.
// Optional feature macro: RTP_SCHED_INTERLACE_EN (adds cfg_interlaced and a
// toggling field bit; without it desc_field is constant 0).
`timescale 1ns/1ps

module rtp_packet_scheduler #(
    parameter int GAP_CYCLES = 16,
    parameter int LINE_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [31:0]       timestamp_in,
    input  logic [15:0]       cfg_line_bytes,
    input  logic [LINE_W-1:0] cfg_lines,
    input  logic [15:0]       cfg_payload_bytes,
    input  logic              cfg_seq_load,
    input  logic [31:0]       cfg_seq_init,
`ifdef RTP_SCHED_INTERLACE_EN
    input  logic              cfg_interlaced,
`endif
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       desc_seq,
    output logic [31:0]       desc_timestamp,
    output logic              desc_marker,
    output logic [LINE_W-1:0] desc_line,
    output logic [14:0]       desc_offset,
    output logic [15:0]       desc_length,
    output logic              desc_field,
    input  logic              pkt_done,
    output logic              busy,
    output logic              frame_overrun,
    output logic              cfg_error
);

    // Gap counter counts GAP_CYCLES-1 down to 0.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [15:0]       line_bytes_reg;
    logic [LINE_W-1:0] lines_reg;
    logic [15:0]       payload_reg;
    logic [31:0]       timestamp_reg;
    logic [LINE_W-1:0] line_reg;
    logic [15:0]       offset_reg;
    logic [15:0]       length_reg;
    logic              marker_reg;
    logic [31:0]       seq_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic              overrun_reg;
    logic              cfg_error_reg;

    logic              start_req;
    logic              cfg_zero;
    logic              start_ok;
    logic              handshake;
    logic [15:0]       remaining;
    logic [15:0]       calc_length;
    logic [15:0]       calc_end;
    logic              calc_marker;
    logic [15:0]       done_end;

    assign start_req   = frame_start & enable;
    assign cfg_zero    = (cfg_line_bytes == 16'd0) || (cfg_lines == '0) ||
                         (cfg_payload_bytes == 16'd0);
    assign start_ok    = (state_reg == ST_IDLE) && start_req && !cfg_zero;
    assign handshake   = (state_reg == ST_ISSUE) && desc_ready;

    // Segment of the current line that the next packet covers.
    assign remaining   = line_bytes_reg - offset_reg;
    assign calc_length = (payload_reg < remaining) ? payload_reg : remaining;
    assign calc_end    = offset_reg + calc_length;
    assign calc_marker = (line_reg == (lines_reg - LINE_W'(1))) &&
                         (calc_end == line_bytes_reg);
    assign done_end    = offset_reg + length_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a dropped enable ends the frame at the next packet boundary.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) state_next = ST_CALC;
            end
            ST_CALC: begin
                state_next = enable ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                if (desc_ready) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (pkt_done) begin
                    if (marker_reg || !enable) state_next = ST_IDLE;
                    else if (GAP_CYCLES == 0)  state_next = ST_CALC;
                    else                       state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!enable)                 state_next = ST_IDLE;
                else if (gap_cnt_reg == '0)  state_next = ST_CALC;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        desc_valid = (state_reg == ST_ISSUE);
        busy       = (state_reg != ST_IDLE);
    end

    // Frame configuration, packet position, sequence counter and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_bytes_reg <= '0;
            lines_reg      <= '0;
            payload_reg    <= '0;
            timestamp_reg  <= '0;
            line_reg       <= '0;
            offset_reg     <= '0;
            length_reg     <= '0;
            marker_reg     <= 1'b0;
            seq_reg        <= '0;
            gap_cnt_reg    <= '0;
            overrun_reg    <= 1'b0;
            cfg_error_reg  <= 1'b0;
        end else begin
            overrun_reg   <= frame_start && (state_reg != ST_IDLE);
            cfg_error_reg <= (state_reg == ST_IDLE) && start_req && cfg_zero;

            // A load in IDLE takes priority, so a same-cycle frame starts from it.
            if ((state_reg == ST_IDLE) && cfg_seq_load) begin
                seq_reg <= cfg_seq_init;
            end else if (handshake) begin
                seq_reg <= seq_reg + 32'd1;
            end

            if (start_ok) begin
                line_bytes_reg <= cfg_line_bytes;
                lines_reg      <= cfg_lines;
                payload_reg    <= cfg_payload_bytes;
                timestamp_reg  <= timestamp_in;
                line_reg       <= '0;
                offset_reg     <= '0;
            end

            if (state_reg == ST_CALC) begin
                length_reg <= calc_length;
                marker_reg <= calc_marker;
            end

            if ((state_reg == ST_WAIT_DONE) && pkt_done) begin
                if (done_end == line_bytes_reg) begin
                    offset_reg <= '0;
                    line_reg   <= line_reg + LINE_W'(1);
                end else begin
                    offset_reg <= done_end;
                end
            end

            if (state_reg == ST_WAIT_DONE) begin
                gap_cnt_reg <= GAP_W'(GAP_CYCLES - 1);
            end else if ((state_reg == ST_GAP) && (gap_cnt_reg != '0)) begin
                gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
            end
        end
    end

`ifdef RTP_SCHED_INTERLACE_EN
    logic field_reg;
    logic field_toggle_reg;

    // Field bit alternates per accepted interlaced frame, first frame is field 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            field_reg        <= 1'b0;
            field_toggle_reg <= 1'b0;
        end else if (start_ok) begin
            if (cfg_interlaced) begin
                field_reg        <= field_toggle_reg;
                field_toggle_reg <= ~field_toggle_reg;
            end else begin
                field_reg <= 1'b0;
            end
        end
    end

    assign desc_field = field_reg;
`else
    assign desc_field = 1'b0;
`endif

    assign desc_seq       = seq_reg;
    assign desc_timestamp = timestamp_reg;
    assign desc_marker    = marker_reg;
    assign desc_line      = line_reg;
    assign desc_offset    = offset_reg[14:0];
    assign desc_length    = length_reg;
    assign frame_overrun  = overrun_reg;
    assign cfg_error      = cfg_error_reg;

endmodule

// File: doc/rtp_packet_scheduler.md
# rtp_packet_scheduler

Sequencing controller for the RTP transmit engine. Splits each video frame into line-aligned RTP packets. Issues one packet descriptor per packet to the transmit state machine over a valid/ready handshake: extended sequence number, timestamp, marker, line number, offset and length. Waits for packet completion, enforces a programmable inter-packet gap, and sits between the frame/line timing source and the RTP header/payload transmitter.

## Interface
Parameters:
- GAP_CYCLES, 16: idle cycles between `pkt_done` and the next descriptor; 0 is legal.
- LINE_W, 15: width of the line counter, matching the payload-header line field.

Ports:
- clk  in  1  engine clock; one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  scheduler enable.
- frame_start  in  1  single-cycle pulse at the start of a frame.
- timestamp_in  in  32  RTP timestamp, sampled on an accepted `frame_start`.
- cfg_line_bytes  in  16  payload bytes per video line.
- cfg_lines  in  LINE_W  lines per frame.
- cfg_payload_bytes  in  16  maximum payload bytes per packet.
- cfg_seq_load  in  1  pulse; loads `cfg_seq_init` into the sequence counter. Honoured only in IDLE.
- cfg_seq_init  in  32  initial extended sequence value, laid out {ext_seq_num, sequence_nr}.
- desc_valid  out  1  descriptor valid.
- desc_ready  in  1  transmitter accepts the descriptor.
- desc_seq  out  32  {ext_seq_num[15:0], sequence_nr[15:0]}.
- desc_timestamp  out  32  frame timestamp.
- desc_marker  out  1  set on the last packet of the frame.
- desc_line  out  LINE_W  line number.
- desc_offset  out  15  byte offset within the line.
- desc_length  out  16  payload length in bytes.
- desc_field  out  1  field identification bit.
- pkt_done  in  1  pulse; transmitter finished the accepted packet.
- busy  out  1  high in any state other than IDLE.
- frame_overrun  out  1  one-cycle pulse; `frame_start` arrived while busy.
- cfg_error  out  1  one-cycle pulse; frame rejected because of zero configuration.

## Operation
States:
- **IDLE**
  - On `frame_start & enable`, latch the three `cfg_*` size inputs and `timestamp_in`, clear line and offset, then go to CALC.
  - If any latched size input is zero, pulse `cfg_error` and stay in IDLE instead.
- **CALC**
  - desc_length = min(cfg_payload_bytes, line_bytes − offset).
  - desc_marker = (line == lines−1) && (offset + desc_length == line_bytes).
  - Next state is ISSUE.
- **ISSUE**
  - Assert `desc_valid`. All desc_* outputs are held stable until `desc_ready`.
  - On the handshake, increment the sequence counter (32-bit, wraps 0xFFFFFFFF→0) and go to WAIT_DONE.
- **WAIT_DONE**
  - On `pkt_done`, compute offset += length. When the offset reaches line_bytes, set offset = 0 and line += 1.
  - If the packet carried the marker, go to IDLE. Otherwise go to GAP (or straight to CALC when GAP_CYCLES = 0).
- **GAP**
  - Count GAP_CYCLES cycles, then go to CALC.

Sequence and handshake rules:
- Each packet carries exactly one line segment. The continuation bit is implied 0.
- The sequence counter is never cleared between frames; only `reset` or `cfg_seq_load` change it.
- `desc_seq` shows the value before the increment.

Boundary conditions:
- `frame_start` while busy: ignored, `frame_overrun` pulses, and the current frame is undisturbed.
- `enable` deasserted mid-frame: the current packet completes through WAIT_DONE, then the scheduler returns to IDLE. No marker is sent and the sequence counter is kept.
- `pkt_done` outside WAIT_DONE is ignored.
- `cfg_seq_load` outside IDLE is ignored.
- `cfg_seq_load` and `frame_start` in the same IDLE cycle: the load wins, and the first packet uses `cfg_seq_init`.
- `reset` mid-frame: return to IDLE immediately. Drop `desc_valid`, clear all counters. The sequence counter resets to 0.

## Timing
- All outputs reset to 0.
- `frame_start` accepted at cycle N: CALC at N+1, `desc_valid` high at N+2.
- `desc_valid` deasserts in the cycle after the handshake.
- `pkt_done` at cycle M with GAP_CYCLES = G:
  - G > 0: next `desc_valid` at M+G+2.
  - G = 0: next `desc_valid` at M+2.
- `busy` goes low the cycle after the marker packet's `pkt_done`.
- Status pulses (`frame_overrun`, `cfg_error`) assert in the cycle after the triggering input and last exactly one cycle.

## Configuration
- Macro: `RTP_SCHED_INTERLACE_EN`.
- **Defined:**
  - Adds input `cfg_interlaced` (1 bit).
  - While `cfg_interlaced` = 1, `desc_field` toggles on every accepted frame, starting at 0 for the first frame after reset.
  - `cfg_interlaced` is latched with the other configuration inputs.
- **Undefined:**
  - The `cfg_interlaced` port does not exist.
  - `desc_field` is constant 0.

## Test plan
- line_bytes = 3000, payload = 1200, lines = 2 -> six descriptors:
  - lengths 1200/1200/600, offsets 0/1200/2400, for lines 0 then 1.
  - seq 0..5; marker only on the sixth descriptor.
- GAP_CYCLES = 16, `desc_ready` tied high -> `desc_valid` exactly 18 cycles after each `pkt_done`.
  - `desc_ready` held low for 5 cycles -> desc_* stable throughout.
- `cfg_seq_init` = 0xFFFFFFFE, three-packet frame -> desc_seq 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- `frame_start` mid-frame -> `frame_overrun` pulse of 1 cycle, packet count unchanged.
  - cfg_lines = 0 -> `cfg_error` pulse, no descriptor, `busy` stays 0.
- `enable` dropped during packet 2 of 6 -> packet 2 completes, IDLE, no marker.
  - `reset` asserted in WAIT_DONE -> all outputs 0 the next cycle.
- With `RTP_SCHED_INTERLACE_EN` and `cfg_interlaced` = 1, three frames -> `desc_field` 0, 1, 0.
